volts_to_code: RTL and testbench
================================

// Module: volts_to_code
// PURPOSE
//  Inverse of the XADC-to-digits display path. Takes a 7-digit BCD reading
//  dig6.dig5..dig0 (volts, 1 integer digit + 6 fractional) and produces the
//  16-bit left-justified XADC-style code: data = {code[11:0], 4'b0000}.
//  code = V_u*1024/250000, where V_u = decimal value in microvolts.
//  Iterative (accumulate + restoring divide). start/busy/done handshake.
// PARAMETERS
//  FS_UV     250000  microvolts per 1024 codes (divisor)
//  SHIFT     10      left shift applied to V_u before the divide
//  CODE_MAX  4095    saturation value of the 12-bit code
// PORTS
//  CLK100MHZ  in   1   system clock, all state on rising edge
//  reset      in   1   asynchronous, active-high; clears all state
//  start      in   1   1-cycle request; sampled only while busy==0
//  dig0..dig6 in   4   BCD digits each; dig0 = 1 uV, dig6 = 1 V
//  busy       out  1   high from the cycle after start accept to the cycle before done
//  done       out  1   1-cycle pulse; data/err/ovf valid from this cycle
//  data       out  16  {code,4'b0}; holds its value until next successful done
//  err        out  1   any latched digit > 9 (sticky until next accepted start)
//  ovf        out  1   code saturated to CODE_MAX (sticky until next accepted start)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, data=16'h0000, err=0, ovf=0, internals 0.
//  FSM: IDLE -> LOAD -> ACCUM -> SCALE -> DIV -> DONE -> IDLE.
//  - IDLE: start=1 latches dig0..dig6, clears err/ovf, goes to LOAD (cycle 0).
//  - LOAD (cycle 1): any digit > 9 -> err=1, go to DONE; data unchanged.
//  - ACCUM (7 cycles): acc = acc*10 + digit, dig6 first. acc is 24 bits
//    (max 9,999,999).
//  - SCALE (1 cycle): dividend = acc << SHIFT (34 bits). The optional
//    rounding term is added in this same cycle.
//  - DIV (35 cycles): restoring divide by FS_UV, 1 quotient bit per cycle,
//    MSB first. Remainder is 19 bits. Quotient is 35 bits.
//  - DONE (1 cycle): done=1, busy=0. If quotient > CODE_MAX, then
//    code = CODE_MAX and ovf=1. Otherwise code = quotient[11:0].
//    data = {code,4'b0}.
//  Latency: start accepted at cycle 0 -> done at cycle 45 (normal path).
//    Error path: done at cycle 2.
//  busy=1 in LOAD, ACCUM, SCALE and DIV. start while busy=1 is ignored, not queued.
//  start in the DONE cycle (busy=0) is accepted, giving back-to-back operation.
//    It latches the new digits, clears err/ovf and goes to LOAD.
//  Digit inputs may change freely after the accept cycle; only latched copies are used.
//  Reset asserted mid-operation: immediate return to reset values, no done pulse.
//  V_u = 1000000 (1.000000 V) yields 4096 -> saturates to 4095, ovf=1.
//    This matches the display path's 1 V clamp.
// CONFIGURATION
//  VOLTS_ROUND_EN defined:
//    dividend = (acc << SHIFT) + FS_UV/2, i.e. round half up to the nearest code.
//  VOLTS_ROUND_EN undefined:
//    dividend = acc << SHIFT, i.e. truncate toward zero.
//  Latency, handshake and saturation rules are identical in both builds.
// TESTING
//  1. reset, digits 0.500000, start -> done @cycle 45, data=16'h8000, err=0, ovf=0
//  2. digits 0.999755 -> truncate: data=16'hFFE0 (4094).
//     With VOLTS_ROUND_EN: data=16'hFFF0 (4095), ovf=0.
//  3. digits 1.000000 -> data=16'hFFF0, ovf=1.
//     digits 9.999999 -> data=16'hFFF0, ovf=1.
//  4. dig3=4'hA, start -> done @cycle 2, err=1, data keeps prior value.
//     Next valid start clears err.
//  5. start pulsed again at cycles 5 and 20 -> ignored, single done @45.
//     start in done cycle -> second done 45 cycles later.
//  6. reset asserted at cycle 20 mid-DIV -> busy=0, data=0 immediately, no done pulse.
//     Subsequent 0.000244 -> data=16'h0000 (trunc; 0.99 code).
//     With VOLTS_ROUND_EN: data=16'h0010.

Source files
------------

// File: rtl/volts_to_code.sv
// rtl/volts_to_code.sv - 7-digit BCD volts reading to 16-bit left-justified XADC code
//
// Purpose: converts a BCD reading dig6.dig5..dig0 (1 V .. 1 uV per digit) into
//   data = {code[11:0], 4'b0000}, code = V_uV * 1024 / 250000, saturating at 4095.
//   Iterative: decimal accumulate (7 cycles), scale, restoring divide (35 cycles).
// Configuration: define VOLTS_ROUND_EN to round half up instead of truncating.
// Ports:
//   CLK100MHZ  in   system clock, all state on rising edge
//   reset      in   asynchronous active-high reset
//   start      in   request; accepted only while idle or in the done cycle
//   dig0..dig6 in   BCD digits, dig0 = 1 uV, dig6 = 1 V
//   busy       out  high in LOAD/ACCUM/SCALE/DIV
//   done       out  one-cycle completion pulse
//   data       out  {code,4'b0}, held until the next successful conversion
//   err        out  a latched digit was > 9 (sticky until next accepted start)
//   ovf        out  code saturated (sticky until next accepted start)
module volts_to_code #(
  parameter int FS_UV    = 250000,
  parameter int SHIFT    = 10,
  parameter int CODE_MAX = 4095
) (
  input  logic        CLK100MHZ,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  dig0,
  input  logic [3:0]  dig1,
  input  logic [3:0]  dig2,
  input  logic [3:0]  dig3,
  input  logic [3:0]  dig4,
  input  logic [3:0]  dig5,
  input  logic [3:0]  dig6,
  output logic        busy,
  output logic        done,
  output logic [15:0] data,
  output logic        err,
  output logic        ovf
);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, SCALE, DIV, DONE} state_t;

`ifdef VOLTS_ROUND_EN
  localparam logic [34:0] ROUND_TERM = 35'(FS_UV / 2);
`else
  localparam logic [34:0] ROUND_TERM = '0;
`endif
  localparam logic [18:0] DIVISOR  = 19'(FS_UV);
  localparam logic [11:0] CODE_SAT = 12'(CODE_MAX);

  state_t      state, state_next;
  logic [27:0] digs;      // latched {dig6..dig0}
  logic [23:0] acc;
  logic [2:0]  acc_idx;   // digit being accumulated, 6 down to 0
  logic [5:0]  div_cnt;
  logic [34:0] dvd;       // dividend, shifted out MSB first
  logic [34:0] quot;
  logic [18:0] rem;

  logic [3:0]  cur_dig;
  logic        dig_bad;
  logic [18:0] trial;
  logic        trial_ge;
  logic [34:0] quot_shift;
  logic        accept;

  always_comb begin
    cur_dig = digs[{acc_idx, 2'b00} +: 4];
    dig_bad = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (digs[k*4 +: 4] > 4'd9) dig_bad = 1'b1;
    end
    // Restoring step: bring down the next dividend bit, subtract if it fits.
    trial      = (rem << 1) | 19'(dvd[34]);
    trial_ge   = (trial >= DIVISOR);
    quot_shift = (quot << 1) | 35'(trial_ge);
    accept     = start && (state == IDLE || state == DONE);
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = LOAD;
      LOAD:  begin
        busy       = 1'b1;
        state_next = dig_bad ? DONE : ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (acc_idx == 3'd0) state_next = SCALE;
      end
      SCALE: begin
        busy       = 1'b1;
        state_next = DIV;
      end
      DIV:   begin
        busy = 1'b1;
        if (div_cnt == 6'd34) state_next = DONE;
      end
      DONE:  begin
        done       = 1'b1;
        state_next = start ? LOAD : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ or posedge reset) begin
    if (reset) begin
      digs    <= '0;
      acc     <= '0;
      acc_idx <= '0;
      div_cnt <= '0;
      dvd     <= '0;
      quot    <= '0;
      rem     <= '0;
      data    <= '0;
      err     <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (accept) begin
        digs <= {dig6, dig5, dig4, dig3, dig2, dig1, dig0};
        err  <= 1'b0;
        ovf  <= 1'b0;
      end
      case (state)
        LOAD: begin
          acc     <= '0;
          acc_idx <= 3'd6;
          if (dig_bad) err <= 1'b1;
        end
        ACCUM: begin
          acc     <= acc * 24'd10 + {20'd0, cur_dig};
          acc_idx <= acc_idx - 3'd1;
        end
        SCALE: begin
          dvd     <= (35'(acc) << SHIFT) + ROUND_TERM;
          rem     <= '0;
          quot    <= '0;
          div_cnt <= '0;
        end
        DIV: begin
          rem     <= trial_ge ? (trial - DIVISOR) : trial;
          dvd     <= dvd << 1;
          quot    <= quot_shift;
          div_cnt <= div_cnt + 6'd1;
          // Final quotient bit lands on this edge, so data is valid in DONE.
          if (div_cnt == 6'd34) begin
            if (quot_shift > 35'(CODE_MAX)) begin
              data <= {CODE_SAT, 4'b0000};
              ovf  <= 1'b1;
            end else begin
              data <= {quot_shift[11:0], 4'b0000};
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_volts_to_code.sv
// tb/tb_volts_to_code.sv - scoreboard bench for volts_to_code
module tb_volts_to_code;

  logic        CLK100MHZ = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  dig0 = '0, dig1 = '0, dig2 = '0, dig3 = '0, dig4 = '0, dig5 = '0, dig6 = '0;
  logic        busy, done, err, ovf;
  logic [15:0] data;

  volts_to_code dut (
    .CLK100MHZ(CLK100MHZ), .reset(reset), .start(start),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .dig4(dig4), .dig5(dig5), .dig6(dig6),
    .busy(busy), .done(done), .data(data), .err(err), .ovf(ovf)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  int cyc = 0;
  always @(posedge CLK100MHZ) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic        err;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_data = '0;

`ifdef VOLTS_ROUND_EN
  localparam longint RND = 125000;
`else
  localparam longint RND = 0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value in microvolts, then plain integer scaling.
  function automatic exp_t model(input logic [27:0] d, input int c);
    exp_t   e;
    longint v = 0;
    longint q;
    bit     bad = 0;
    for (int k = 6; k >= 0; k--) begin
      logic [3:0] x;
      x = d[k*4 +: 4];
      if (x > 9) bad = 1;
      v = v * 10 + longint'(x);
    end
    if (bad) begin
      e.data = last_data; e.err = 1'b1; e.ovf = 1'b0; e.cyc = c + 2;
    end else begin
      q = (v * 1024 + RND) / 250000;
      e.err = 1'b0;
      e.cyc = c + 45;
      if (q > 4095) begin
        e.data = 16'hFFF0; e.ovf = 1'b1;
      end else begin
        e.data = 16'(q << 4); e.ovf = 1'b0;
      end
      last_data = e.data;
    end
    return e;
  endfunction

  // Monitor: pops and compares on every done pulse.
  always @(negedge CLK100MHZ) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("data", 32'(data), 32'(e.data));
        chk("err", 32'(err), 32'(e.err));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency_cycle", cyc, e.cyc);
        chk("busy_in_done", 32'(busy), 0);
      end
    end
  end

  task automatic set_digs(input logic [27:0] d);
    {dig6, dig5, dig4, dig3, dig2, dig1, dig0} = d;
  endtask

  // Called at a negedge in an idle or done cycle; returns the accept cycle count.
  task automatic issue(input logic [27:0] d, output int c);
    c = cyc;
    set_digs(d);
    start = 1'b1;
    sb.push_back(model(d, c));
    @(negedge CLK100MHZ);
    start = 1'b0;
    set_digs(28'($urandom));
    chk("busy_load", 32'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 200) begin
      @(negedge CLK100MHZ);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no done in %0d cycles expected done", n);
    end
  endtask

  task automatic pulse_start_at(input int c_at);
    while (cyc < c_at) @(negedge CLK100MHZ);
    set_digs(28'($urandom));
    start = 1'b1;
    @(negedge CLK100MHZ);
    start = 1'b0;
  endtask

  function automatic logic [27:0] rand_digs();
    logic [27:0] d;
    for (int k = 0; k < 7; k++) d[k*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 7) == 0) d[$urandom_range(0, 6)*4 +: 4] = 4'($urandom_range(10, 15));
    else if ($urandom_range(0, 3) == 0) d[27:24] = 4'($urandom_range(0, 1));
    return d;
  endfunction

  initial begin
    int c;
    repeat (2) @(negedge CLK100MHZ);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_ovf", 32'(ovf), 0);
    reset = 1'b0;
    @(negedge CLK100MHZ);

    // 0.5 V with ignored starts during busy, then back-to-back start in done cycle.
    issue(28'h0500000, c);
    pulse_start_at(c + 5);
    pulse_start_at(c + 20);
    wait_done();
    issue(28'h0999755, c);
    wait_done();
    @(negedge CLK100MHZ);

    // Saturation points.
    issue(28'h1000000, c);
    wait_done();
    @(negedge CLK100MHZ);
    issue(28'h9999999, c);
    wait_done();
    @(negedge CLK100MHZ);

    // Bad digit, then a valid start clears err.
    issue(28'h000A000, c);
    wait_done();
    @(negedge CLK100MHZ);
    issue(28'h0123456, c);
    wait_done();
    @(negedge CLK100MHZ);

    // Reset mid-divide: outputs return to reset values, no done follows.
    issue(28'h0777777, c);
    while (cyc < c + 20) @(negedge CLK100MHZ);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_data", 32'(data), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    sb.delete();
    last_data = '0;
    repeat (2) @(negedge CLK100MHZ);
    reset = 1'b0;
    repeat (60) @(negedge CLK100MHZ);

    issue(28'h0000244, c);
    wait_done();
    @(negedge CLK100MHZ);

    // Randomized conversions with random gaps and occasional back-to-back starts.
    for (int i = 0; i < 30; i++) begin
      issue(rand_digs(), c);
      wait_done();
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 4)) @(negedge CLK100MHZ);
    end

    repeat (5) @(negedge CLK100MHZ);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
